// File: rtl/serial_adder_pkg.sv
// serial_adder shared types and defaults.
// Imported by the serial adder top and its full-adder cell.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: one-bit full adder cell.
// The only arithmetic in the serial adder datapath.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_carry
);

    // sum and majority carry of the three inputs
    always_comb begin
        o_sum   = i_a ^ i_b ^ i_cin;
        o_carry = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
    end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one bit per clock.
// Registered carry around a single full_adder cell.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] acc_ext;

    full_adder u_fa (
        .i_a     (sa_q[0]),
        .i_b     (sb_q[0]),
        .i_cin   (c_q),
        .o_sum   (fa_s),
        .o_carry (fa_c)
    );

    // new sum bit enters at the top; the low bit drops off
    assign acc_ext = {fa_s, acc_q};

    // next-state, shift and completion logic
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    sa_d    = i_a;
                    sb_d    = i_b;
                    c_d     = i_cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                acc_d = acc_ext[WIDTH-1:1];
                c_d   = fa_c;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = acc_ext;
                    cout_d  = fa_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // all state registers, cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_sum  = sum_q;
    assign o_cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder.
// Three instances cover WIDTH = 2, 8 and 16.
module tb_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        st   [3];
    logic [15:0] ain  [3];
    logic [15:0] bin  [3];
    logic        cin_i[3];
    logic        bsy  [3];
    logic        dn   [3];
    logic        co   [3];
    logic [1:0]  s2;
    logic [7:0]  s8;
    logic [15:0] s16;

    int n_chk  = 0;
    int n_pass = 0;

    serial_adder #(.WIDTH(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st[0]),
        .i_a(ain[0][1:0]), .i_b(bin[0][1:0]), .i_cin(cin_i[0]),
        .o_busy(bsy[0]), .o_done(dn[0]), .o_sum(s2), .o_cout(co[0])
    );

    serial_adder #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st[1]),
        .i_a(ain[1][7:0]), .i_b(bin[1][7:0]), .i_cin(cin_i[1]),
        .o_busy(bsy[1]), .o_done(dn[1]), .o_sum(s8), .o_cout(co[1])
    );

    serial_adder #(.WIDTH(16)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st[2]),
        .i_a(ain[2]), .i_b(bin[2]), .i_cin(cin_i[2]),
        .o_busy(bsy[2]), .o_done(dn[2]), .o_sum(s16), .o_cout(co[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wd(input int d);
        case (d)
            0:       return 2;
            1:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic logic [15:0] g_sum(input int d);
        case (d)
            0:       return {14'd0, s2};
            1:       return {8'd0, s8};
            default: return s16;
        endcase
    endfunction

    // reference: plain integer addition, truncated to the width
    function automatic logic [63:0] ref_add(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic c);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return ({48'd0, a} & m) + ({48'd0, b} & m) + {63'd0, c};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // call at #1 after an edge; returns at #1 after the accepting edge
    task automatic start_op(input int d, input logic [15:0] a, input logic [15:0] b,
                            input logic c, input bit hold);
        st[d] = 1'b1; ain[d] = a; bin[d] = b; cin_i[d] = c;
        @(posedge clk); #1;
        st[d] = hold;
        ain[d] = 16'($urandom); bin[d] = 16'($urandom); cin_i[d] = 1'($urandom);
        chk("busy_after_start", bsy[d], 1'b1);
    endtask

    // returns at #1 after the done edge
    task automatic wait_done(input int d, input logic [15:0] a, input logic [15:0] b,
                             input logic c, input bit scramble);
        int w;
        int n;
        bit ok;
        logic [15:0] held;
        logic [63:0] full;
        logic [63:0] m;
        w = wd(d);
        m = (64'd1 << w) - 64'd1;
        full = ref_add(w, a, b, c);
        held = g_sum(d);
        n = 0;
        ok = 1'b1;
        while (dn[d] !== 1'b1 && n < w + 4) begin
            @(posedge clk); #1;
            n++;
            if (scramble) begin
                ain[d] = 16'($urandom); bin[d] = 16'($urandom); cin_i[d] = 1'($urandom);
            end
            if (dn[d] !== 1'b1 && (bsy[d] !== 1'b1 || g_sum(d) !== held)) ok = 1'b0;
        end
        st[d] = 1'b0;
        chk("latency", 64'(n), 64'(w));
        chk("busy_and_sum_hold", {63'd0, ok}, 64'd1);
        chk("sum", {48'd0, g_sum(d)}, full & m);
        chk("cout", {63'd0, co[d]}, (full >> w) & 64'd1);
        chk("busy_low_at_done", bsy[d], 1'b0);
    endtask

    task automatic end_op(input int d);
        logic [15:0] held;
        held = g_sum(d);
        @(posedge clk); #1;
        chk("done_one_cycle", dn[d], 1'b0);
        chk("sum_held_after_done", g_sum(d), held);
    endtask

    task automatic op(input int d, input logic [15:0] a, input logic [15:0] b, input logic c);
        start_op(d, a, b, c, 1'b0);
        wait_done(d, a, b, c, 1'b0);
        end_op(d);
    endtask

    initial begin
        bit seen;
        logic [15:0] ra;
        logic [15:0] rb;
        logic rc;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0; ain[i] = '0; bin[i] = '0; cin_i[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", bsy[i], 1'b0);
            chk("rst_done", dn[i], 1'b0);
            chk("rst_sum", g_sum(i), 16'd0);
            chk("rst_cout", co[i], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op(1, 16'h3C, 16'h5A, 1'b0);
        op(1, 16'hFF, 16'h01, 1'b0);
        op(1, 16'hFF, 16'hFF, 1'b1);

        // start held high, operands churning after acceptance
        start_op(1, 16'hA7, 16'h6D, 1'b1, 1'b1);
        wait_done(1, 16'hA7, 16'h6D, 1'b1, 1'b1);
        end_op(1);
        chk("no_restart_busy", bsy[1], 1'b0);

        // back-to-back start in the done cycle
        start_op(1, 16'h3C, 16'h5A, 1'b0, 1'b0);
        wait_done(1, 16'h3C, 16'h5A, 1'b0, 1'b0);
        start_op(1, 16'h01, 16'h02, 1'b0, 1'b0);
        chk("b2b_prev_sum_held", g_sum(1), 16'h96);
        wait_done(1, 16'h01, 16'h02, 1'b0, 1'b0);
        end_op(1);

        // reset mid-operation
        start_op(1, 16'hC3, 16'h55, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bsy[1], 1'b0);
        chk("abort_done", dn[1], 1'b0);
        chk("abort_sum", g_sum(1), 16'd0);
        chk("abort_cout", co[1], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (dn[1] === 1'b1 || bsy[1] === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", {63'd0, seen}, 64'd0);
        op(1, 16'h10, 16'h20, 1'b0);

        // random sweep on every width, plus the 0+0+1 corner
        for (int d = 0; d < 3; d++) begin
            op(d, 16'h0, 16'h0, 1'b1);
            for (int k = 0; k < 15; k++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                op(d, ra, rb, rc);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder wrapping one `full_adder` cell with a registered carry. It adds two WIDTH-bit operands LSB-first, one bit per clock, over WIDTH cycles. It takes a start pulse from the controlling logic and returns a one-cycle done pulse with the sum held stable. It trades latency for area wherever a wide parallel adder is too costly.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 2

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_start  input  1  request; sampled only while idle
- i_a  input  WIDTH  operand A; captured on the accepting edge
- i_b  input  WIDTH  operand B; captured on the accepting edge
- i_cin  input  1  carry-in; captured on the accepting edge
- o_busy  output  1  high while an addition is in progress
- o_done  output  1  one-cycle pulse; o_sum and o_cout are valid
- o_sum  output  WIDTH  result; held until the next completion
- o_cout  output  1  carry-out of the MSB; held with o_sum

## Operation
- FSM has two states: IDLE and SHIFT.
- IDLE with i_start=1, on the edge:
  - load i_a and i_b into shift registers sa and sb
  - carry register c <= i_cin
  - bit counter cnt <= 0
  - go to SHIFT; o_busy <= 1
- IDLE with i_start=0: no state change.
- SHIFT, each edge:
  - the full_adder is fed sa[0], sb[0] and c
  - sa and sb shift right by one
  - the full_adder sum bit shifts into the MSB of accumulator acc (acc shifts right)
  - c <= the full_adder carry
  - cnt <= cnt+1
- SHIFT with cnt == WIDTH-1, on the edge:
  - o_sum <= the final acc value, with the current sum bit as its MSB
  - o_cout <= the full_adder carry
  - o_done <= 1 and o_busy <= 0
  - go to IDLE
- o_done is registered and high for exactly one cycle. It is cleared on the next edge.
- i_start during SHIFT is ignored. It is not queued.
- i_a, i_b and i_cin may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH. o_cout is bit WIDTH of a+b+cin.
- cnt width is $clog2(WIDTH).

## Timing
- Reset values, applied asynchronously on i_rst_n=0:
  - state = IDLE
  - o_busy = 0, o_done = 0, o_sum = 0, o_cout = 0
  - sa = sb = acc = 0, c = 0, cnt = 0
- Latency: i_start is accepted at edge E0. o_done, o_sum and o_cout become valid after edge E_WIDTH, so latency is WIDTH cycles.
- o_busy is high from after E0 until after E_WIDTH.
- Back-to-back: i_start=1 in the o_done cycle is accepted, since the state is already IDLE. Maximum throughput is one result per WIDTH+1 cycles.
- o_sum and o_cout change only at a completion edge or on reset. A new start does not disturb them until its own completion.
- Reset mid-operation aborts the addition. No o_done is produced, outputs return to 0, and the first start after reset deassertion starts cleanly.
- Reset deassertion is taken synchronously by the surrounding reset synchroniser. The block adds no extra cycle.

## Structure
- Package serial_adder_pkg holds:
  - the state enum typedef (IDLE, SHIFT)
  - localparam for the default WIDTH
- Sub-module: exactly one instance of the existing full_adder cell (i_a, i_b, i_cin -> o_sum, o_carry). It is the only combinational arithmetic in the block.
- Everything else is flops plus the next-state and counter logic in this module.

## Test plan
- WIDTH=8, start with a=0x3C, b=0x5A, cin=0 -> after 8 edges o_done=1 for one cycle, o_sum=0x96, o_cout=0; o_busy high for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 -> o_sum=0x00, o_cout=1. Then a=0xFF, b=0xFF, cin=1 -> o_sum=0xFF, o_cout=1.
- i_start held high for the whole operation, with operand inputs changed every cycle after acceptance -> a single result is produced from the captured operands, with no restart mid-operation.
- Start in the o_done cycle with a=0x01, b=0x02 -> busy resumes immediately. The previous o_sum is held until the new done, then o_sum=0x03.
- i_rst_n pulled low at edge 4 of an operation -> outputs are 0 immediately and no o_done is produced. A following start with 0x10+0x20 -> o_sum=0x30.
- Randomised sweep for WIDTH=2, 8 and 16 against a reference sum, including a=b=0 with cin=1 -> o_sum=1, o_cout=0.
